// File: rtl/wall_map_pkg.sv
// Shared game constants and map controller state type.
// Grid is 640x480 px at 10 px per cell, minus the status bar.
package wall_map_pkg;

   localparam int STATUS_BAR_HEIGHT = 4;
   localparam int MAP_W = 64;
   localparam int MAP_H = 48 - STATUS_BAR_HEIGHT;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

endpackage

// File: rtl/wall_map_if.sv
// Game-logic access port to the wall map: request out, ack/data back.
interface wall_map_if;

   logic       i_req;
   logic       i_we;
   logic [5:0] i_x;
   logic [5:0] i_y;
   logic       i_wdata;
   logic       o_ack;
   logic       o_rdata;

   modport master (
      output i_req, i_we, i_x, i_y, i_wdata,
      input  o_ack, o_rdata
   );

   modport slave (
      input  i_req, i_we, i_x, i_y, i_wdata,
      output o_ack, o_rdata
   );

endinterface

// File: rtl/wall_map_pattern.sv
// Default wall layout: border walls plus a sparse grid of posts.
module wall_pattern #(
   parameter int MAP_W = wall_map_pkg::MAP_W,
   parameter int MAP_H = wall_map_pkg::MAP_H
) (
   input  logic [5:0] x,
   input  logic [5:0] y,
   output logic       wall
);

   localparam logic [5:0] XL = 6'(MAP_W - 1);
   localparam logic [5:0] YL = 6'(MAP_H - 1);

   logic border;
   logic post;

   assign border = (x == 6'd0) || (x == XL) ||
                   (y == 6'd0) || (y == YL);
   assign post   = (x[3:0] == 4'd8) && (y[2:0] == 3'd3);
   assign wall   = border || post;

endmodule

// File: rtl/wall_map.sv
// Wall bit map shared by the display scanner and the game logic.
module wall_map #(
   parameter int MAP_W = wall_map_pkg::MAP_W,
   parameter int MAP_H = wall_map_pkg::MAP_H
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_vga_buzy,
   input  logic [5:0] i_vga_x,
   input  logic [5:0] i_vga_y,
   output logic       o_vga_is_wall,
   input  logic       i_init,
   output logic       o_ready,
   wall_map_if.slave  game
);

   import wall_map_pkg::*;

   localparam int N  = MAP_W * MAP_H;
   localparam int AW = $clog2(N);
   localparam logic [5:0] XL = 6'(MAP_W - 1);
   localparam logic [5:0] YL = 6'(MAP_H - 1);
   localparam logic [5:0] YH = 6'(MAP_H);

   function automatic logic [AW-1:0] addr(
      input logic [5:0] x,
      input logic [5:0] y
   );
      return AW'(y) * AW'(MAP_W) + AW'(x);
   endfunction

   state_t     state_q, state_d;
   logic [5:0] sx_q, sx_d;
   logic [5:0] sy_q, sy_d;
   logic       ack_q;
   logic       rdata_q;
   logic       vga_q;
   logic       mem [N];

   logic          pat;
   logic          run;
   logic          service;
   logic          g_oob;
   logic          v_oob;
   logic [AW-1:0] s_a;
   logic [AW-1:0] g_a;
   logic [AW-1:0] v_a;

   wall_pattern #(
      .MAP_W (MAP_W),
      .MAP_H (MAP_H)
   ) u_pat (
      .x    (sx_q),
      .y    (sy_q),
      .wall (pat)
   );

   assign run   = (state_q == RUN);
   assign s_a   = addr(sx_q, sy_q);
   assign g_a   = addr(game.i_x, game.i_y);
   assign v_a   = addr(i_vga_x, i_vga_y);
   assign g_oob = (game.i_y >= YH);
   assign v_oob = (i_vga_y >= YH);

   // Ack gating keeps a still-high request from being served twice.
   assign service = run && !i_vga_buzy && !i_init &&
                    game.i_req && !ack_q;

   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      unique case (state_q)
         INIT: begin
            if (i_init) begin
               sx_d = '0;
               sy_d = '0;
            end else if (sx_q == XL) begin
               sx_d = '0;
               if (sy_q == YL) begin
                  sy_d    = '0;
                  state_d = RUN;
               end else begin
                  sy_d = sy_q + 6'd1;
               end
            end else begin
               sx_d = sx_q + 6'd1;
            end
         end
         RUN: begin
            if (i_init) begin
               state_d = INIT;
               sx_d    = '0;
               sy_d    = '0;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         sx_q    <= '0;
         sy_q    <= '0;
         ack_q   <= 1'b0;
         rdata_q <= 1'b0;
         vga_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ack_q   <= service;
         if (service)
            rdata_q <= g_oob || mem[g_a];
         vga_q <= run && (v_oob || mem[v_a]);
      end
   end

   // Single write port: sweep in INIT, game write in RUN.
   always_ff @(posedge clk) begin
      if (state_q == INIT)
         mem[s_a] <= pat;
      else if (service && game.i_we && !g_oob)
         mem[g_a] <= game.i_wdata;
   end

   assign o_ready       = run;
   assign o_vga_is_wall = vga_q && run;
   assign game.o_ack    = ack_q;
   assign game.o_rdata  = rdata_q;

endmodule

// File: tb/tb_wall_map.sv
// Directed self-checking bench for wall_map.
module tb_wall_map;

   logic       clk;
   logic       rst_n;
   logic       i_vga_buzy;
   logic [5:0] i_vga_x;
   logic [5:0] i_vga_y;
   logic       o_vga_is_wall;
   logic       i_init;
   logic       o_ready;
   int         total;
   int         bad;

   wall_map_if g ();

   wall_map dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_vga_buzy    (i_vga_buzy),
      .i_vga_x       (i_vga_x),
      .i_vga_y       (i_vga_y),
      .o_vga_is_wall (o_vga_is_wall),
      .i_init        (i_init),
      .o_ready       (o_ready),
      .game          (g)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(
      input  logic       we,
      input  logic [5:0] x,
      input  logic [5:0] y,
      input  logic       wd,
      output logic       rd,
      output int         lat
   );
      g.i_req   = 1'b1;
      g.i_we    = we;
      g.i_x     = x;
      g.i_y     = y;
      g.i_wdata = wd;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!g.o_ack && lat < 6000);
      rd = g.o_rdata;
      g.i_req = 1'b0;
      g.i_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      total++;
      if (o_ready !== 1'b0 || g.o_ack !== 1'b0 ||
          g.o_rdata !== 1'b0 || o_vga_is_wall !== 1'b0) begin
         bad++;
         $display("FAIL reset: rdy=%b ack=%b rd=%b vga=%b want 0000",
                  o_ready, g.o_ack, g.o_rdata, o_vga_is_wall);
      end
      tick();
      tick();
   endtask

   task automatic test_sweep();
      int early;
      int vga_bad;
      early   = 0;
      vga_bad = 0;
      rst_n = 1'b1;
      i_vga_x = 6'd0;
      i_vga_y = 6'd0;
      for (int i = 1; i <= 2815; i++) begin
         tick();
         if (o_ready !== 1'b0) early++;
         if (o_vga_is_wall !== 1'b0) vga_bad++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL sweep_early: ready high %0d times want 0",
                  early);
      end
      total++;
      if (vga_bad != 0) begin
         bad++;
         $display("FAIL vga_in_init: wall high %0d times want 0",
                  vga_bad);
      end
      tick();
      total++;
      if (o_ready !== 1'b1) begin
         bad++;
         $display("FAIL sweep_2816: ready=%b want 1", o_ready);
      end
   endtask

   task automatic test_pattern();
      logic [5:0] xs [7];
      logic [5:0] ys [7];
      logic       ex [7];
      logic       rd;
      int         lat;
      xs = '{6'd0, 6'd8, 6'd5, 6'd63, 6'd24, 6'd8, 6'd10};
      ys = '{6'd0, 6'd3, 6'd5, 6'd10, 6'd11, 6'd4, 6'd43};
      ex = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         access(1'b0, xs[i], ys[i], 1'b0, rd, lat);
         total++;
         if (lat != 1 || rd !== ex[i]) begin
            bad++;
            $display("FAIL pat(%0d,%0d): rd=%b lat=%0d want %b lat=1",
                     xs[i], ys[i], rd, lat, ex[i]);
         end
         tick();
      end
   endtask

   task automatic test_busy_hold();
      int early;
      early = 0;
      i_vga_buzy = 1'b1;
      g.i_req = 1'b1;
      g.i_we  = 1'b0;
      g.i_x   = 6'd8;
      g.i_y   = 6'd3;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (g.o_ack !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL busy_hold: ack %0d times want 0", early);
      end
      i_vga_buzy = 1'b0;
      tick();
      g.i_req = 1'b0;
      total++;
      if (g.o_ack !== 1'b1 || g.o_rdata !== 1'b1) begin
         bad++;
         $display("FAIL busy_release: ack=%b rd=%b want 1 1",
                  g.o_ack, g.o_rdata);
      end
      tick();
   endtask

   task automatic test_write_read();
      logic rd;
      int   lat;
      access(1'b1, 6'd5, 6'd5, 1'b1, rd, lat);
      total++;
      if (lat != 1 || rd !== 1'b0) begin
         bad++;
         $display("FAIL wr55: rd=%b lat=%0d want 0 lat=1", rd, lat);
      end
      tick();
      access(1'b0, 6'd5, 6'd5, 1'b0, rd, lat);
      total++;
      if (rd !== 1'b1) begin
         bad++;
         $display("FAIL rd55: rd=%b want 1", rd);
      end
      i_vga_x = 6'd5;
      i_vga_y = 6'd5;
      tick();
      total++;
      if (o_vga_is_wall !== 1'b1) begin
         bad++;
         $display("FAIL vga55: wall=%b want 1", o_vga_is_wall);
      end
      i_vga_x = 6'd6;
      tick();
      total++;
      if (o_vga_is_wall !== 1'b0) begin
         bad++;
         $display("FAIL vga65: wall=%b want 0", o_vga_is_wall);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      int dbl;
      logic prev;
      acks = 0;
      dbl  = 0;
      prev = 1'b0;
      g.i_req = 1'b1;
      g.i_we  = 1'b0;
      g.i_x   = 6'd8;
      g.i_y   = 6'd3;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (g.o_ack === 1'b1) acks++;
         if (prev && g.o_ack === 1'b1) dbl++;
         prev = g.o_ack;
      end
      g.i_req = 1'b0;
      total++;
      if (dbl != 0 || acks != 3) begin
         bad++;
         $display("FAIL b2b: acks=%0d dbl=%0d want 3 0", acks, dbl);
      end
      tick();
   endtask

   task automatic test_oob();
      logic rd;
      int   lat;
      i_vga_x = 6'd20;
      i_vga_y = 6'd44;
      tick();
      total++;
      if (o_vga_is_wall !== 1'b1) begin
         bad++;
         $display("FAIL vga_y44: wall=%b want 1", o_vga_is_wall);
      end
      access(1'b1, 6'd3, 6'd50, 1'b0, rd, lat);
      total++;
      if (lat != 1 || rd !== 1'b1) begin
         bad++;
         $display("FAIL wr_oob: rd=%b lat=%0d want 1 lat=1", rd, lat);
      end
      tick();
      access(1'b0, 6'd3, 6'd50, 1'b0, rd, lat);
      total++;
      if (rd !== 1'b1) begin
         bad++;
         $display("FAIL rd_oob: rd=%b want 1", rd);
      end
      tick();
      access(1'b0, 6'd3, 6'd0, 1'b0, rd, lat);
      total++;
      if (rd !== 1'b1) begin
         bad++;
         $display("FAIL rd30: rd=%b want 1", rd);
      end
      tick();
   endtask

   task automatic test_reinit();
      int early;
      int n;
      early = 0;
      i_vga_x = 6'd0;
      i_vga_y = 6'd0;
      i_init = 1'b1;
      tick();
      i_init = 1'b0;
      total++;
      if (o_ready !== 1'b0) begin
         bad++;
         $display("FAIL init_run: ready=%b want 0", o_ready);
      end
      for (int i = 0; i < 1000; i++) tick();
      g.i_req = 1'b1;
      g.i_we  = 1'b0;
      g.i_x   = 6'd5;
      g.i_y   = 6'd5;
      i_init  = 1'b1;
      tick();
      i_init = 1'b0;
      if (g.o_ack !== 1'b0) early++;
      n = 0;
      while (g.o_ack !== 1'b1 && n < 4000) begin
         tick();
         n++;
         if (n <= 2816 && g.o_ack !== 1'b0) early++;
      end
      g.i_req = 1'b0;
      total++;
      if (early != 0 || n != 2817) begin
         bad++;
         $display("FAIL reinit_ack: at=%0d early=%0d want 2817 0",
                  n, early);
      end
      total++;
      if (g.o_rdata !== 1'b0) begin
         bad++;
         $display("FAIL reinit_revert: rd=%b want 0", g.o_rdata);
      end
      tick();
      total++;
      if (g.o_ack !== 1'b0) begin
         bad++;
         $display("FAIL reinit_single: ack=%b want 0", g.o_ack);
      end
   endtask

   task automatic test_reset_mid();
      int early;
      int n;
      early = 0;
      g.i_req   = 1'b1;
      g.i_we    = 1'b1;
      g.i_x     = 6'd5;
      g.i_y     = 6'd5;
      g.i_wdata = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (g.o_ack !== 1'b0 || o_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: ack=%b rdy=%b want 0 0",
                  g.o_ack, o_ready);
      end
      tick();
      tick();
      rst_n = 1'b1;
      n = 0;
      while (g.o_ack !== 1'b1 && n < 4000) begin
         tick();
         n++;
         if (n <= 2816 && g.o_ack !== 1'b0) early++;
      end
      g.i_req = 1'b0;
      g.i_we  = 1'b0;
      total++;
      if (early != 0 || n != 2817) begin
         bad++;
         $display("FAIL rst_sweep: at=%0d early=%0d want 2817 0",
                  n, early);
      end
      total++;
      if (g.o_rdata !== 1'b0) begin
         bad++;
         $display("FAIL rst_old: rd=%b want 0", g.o_rdata);
      end
      tick();
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      i_vga_buzy = 1'b0;
      i_vga_x    = 6'd0;
      i_vga_y    = 6'd0;
      i_init     = 1'b0;
      g.i_req    = 1'b0;
      g.i_we     = 1'b0;
      g.i_x      = 6'd0;
      g.i_y      = 6'd0;
      g.i_wdata  = 1'b0;
      test_reset();
      test_sweep();
      test_pattern();
      test_busy_hold();
      test_write_read();
      test_back_to_back();
      test_oob();
      test_reinit();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wall_map.md
WALL_MAP -- requirements
Module: wall_map

Interface
REQ-001 SHALL have parameter MAP_W, default 64, grid columns (matches 640 px / 10 px per grid).
REQ-002 SHALL have parameter MAP_H, default 44, game-area rows (48 grid rows minus 4-row status bar).
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_vga_buzy, input, 1, display owns the map this cycle.
REQ-006 SHALL have port i_vga_x, input, 6, display request column.
REQ-007 SHALL have port i_vga_y, input, 6, display request row.
REQ-008 SHALL have port o_vga_is_wall, output, 1, wall bit for the last display request.
REQ-009 SHALL have port i_init, input, 1, one-cycle pulse that reloads the default map.
REQ-010 SHALL have port o_ready, output, 1, high when the map is loaded (state RUN).
REQ-011 SHALL have port i_req, input, 1, game-logic access request.
REQ-012 SHALL have port i_we, input, 1, 1 = write, 0 = read; qualified by i_req.
REQ-013 SHALL have ports i_x and i_y, input, 6 each, game access cell.
REQ-014 SHALL have port i_wdata, input, 1, wall bit to write.
REQ-015 SHALL have port o_ack, output, 1, one-cycle pulse when a game access completes.
REQ-016 SHALL have port o_rdata, output, 1, pre-access cell value, valid with o_ack.

Function
REQ-017 SHALL store a MAP_W x MAP_H bit map and perform at most one map access per cycle.
REQ-018 SHALL implement states INIT and RUN.
- INIT sweeps the cells row-major, one cell per cycle, writing the default pattern.
- INIT moves to RUN the cycle after cell (MAP_W-1, MAP_H-1) is written, i.e. MAP_W*MAP_H cycles (2816 by default).
REQ-019 SHALL generate the default pattern as follows.
- Wall where x==0, x==MAP_W-1, y==0 or y==MAP_H-1.
- Also wall where x[3:0]==8 and y[2:0]==3.
- Empty otherwise.
REQ-020 SHALL register o_vga_is_wall one cycle after sampling (i_vga_x, i_vga_y) every cycle in RUN, regardless of i_vga_buzy.
REQ-021 SHALL drive o_vga_is_wall to 0 in INIT.
REQ-022 SHALL return o_vga_is_wall=1 when i_vga_y>=MAP_H.
REQ-023 SHALL service a pending i_req only in a cycle with state RUN and i_vga_buzy==0; o_ack and o_rdata are registered in the following cycle.
REQ-024 SHALL set the cell to i_wdata on a write; o_rdata returns the old value.
REQ-025 SHALL ignore writes with i_y>=MAP_H but still ack them, with o_rdata=1.
REQ-026 SHALL never assert o_ack on two consecutive cycles; the requester drops i_req the cycle after o_ack.
REQ-027 SHALL hold an unserviced i_req pending through any number of busy cycles.
REQ-028 SHALL, on i_init in RUN, enter INIT next cycle with the sweep counter at 0.
REQ-029 SHALL restart the sweep at 0 on i_init in INIT.
REQ-030 SHALL not ack a request while in INIT; a pending request is serviced after RUN is re-entered.
REQ-031 SHALL let i_init win over a game request in the same cycle, which then remains pending.
REQ-032 SHALL give the display access priority over a game access in the same cycle when i_vga_buzy==1.

Reset
REQ-033 SHALL, on rst_n low, enter INIT with sweep counter 0 and set o_vga_is_wall=0, o_ack=0, o_rdata=0, o_ready=0.
REQ-034 SHALL discard any request in flight on reset; the map contents are don't-care until the sweep completes.

Structure
REQ-035 SHALL take MAP_W, MAP_H, STATUS_BAR_HEIGHT and the INIT/RUN state enum from the shared game package.
REQ-036 SHALL place the default pattern in combinational sub-module wall_pattern, mapping (x, y) to a wall bit.

Verification
REQ-037 Reset, then 2816 cycles -> o_ready rises exactly on cycle 2816; read (0,0) gives 1, (8,3) gives 1, (5,5) gives 0.
REQ-038 Hold i_vga_buzy=1 and i_req read (8,3) for 100 cycles, then drop busy -> o_ack comes exactly 1 cycle after busy falls, with o_rdata=1.
REQ-039 Write (5,5)=1 with o_ack, then read (5,5) -> first o_rdata=0, second o_rdata=1; display request (5,5) gives o_vga_is_wall=1 next cycle.
REQ-040 Pulse i_init at sweep cell 1000 with i_req pending -> no ack for 2816 cycles after the pulse, then one ack; a written cell reverts to its pattern value.
REQ-041 Display request y=44 -> o_vga_is_wall=1; game write (3,50)=0 -> acked, o_rdata=1, map unchanged.
REQ-042 Assert rst_n low mid-write -> o_ack=0 and o_ready=0 immediately; a full sweep completes before any ack.
